// File: rtl/data_memory_param.sv
// data_memory_param
//   Single-port word memory with a request/response handshake and an
//   optional power-on clear sequence.
//
//   Build option: define DMEM_CLEAR_EN to include the INIT state that writes
//   zero to every word (one word per cycle) before requests are accepted.
//   Without it the block comes out of reset straight into RUN and memory
//   contents are undefined until written.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     req_valid  request present
//     req_ready  block accepts a request this cycle (RUN only)
//     req_we     1 = write, 0 = read
//     req_addr   word address
//     req_wdata  write data
//     rsp_valid  one-cycle pulse, the cycle after an accepted request
//     rsp_rdata  read data (0 for writes and out-of-range requests), held
//     rsp_err    accepted request addressed at or above DEPTH
//     init_done  memory initialised and usable
module data_memory_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  // Array index width; req_addr may be wider than the array needs.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run_q;
  logic              accept_p0;
  logic              in_range_p0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              vld_p1;
  logic              err_p1;
  logic [DATA_W-1:0] rdata_p1;

  assign accept_p0   = req_valid & run_q;
  assign in_range_p0 = addr_in_range(req_addr);

`ifdef DMEM_CLEAR_EN
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  // run_q is the registered ready/done flag; it rises on the same edge the
  // FSM enters RUN, i.e. the edge that clears word DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      clr_cnt <= '0;
      run_q   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= S_RUN;
            run_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: run_q <= 1'b1;
      endcase
    end
  end

  // The clear sequence owns the write port while in INIT; no requests are
  // accepted then, so there is no conflict.
  always_comb begin
    mem_we    = accept_p0 & req_we & in_range_p0;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end
  end
`else
  // No clear: ready from the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_comb begin
    mem_we    = accept_p0 & req_we & in_range_p0;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
  end
`endif

  // ---- stage p0 -> array: memory is never reset, only written ----
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end
  end

  // ---- stage p0 -> p1: registered response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0;
      err_p1 <= accept_p0 & ~in_range_p0;
      // rdata only updates with a response so it holds between responses.
      if (accept_p0) begin
        rdata_p1 <= (!req_we && in_range_p0) ? mem[req_addr[IDX_W-1:0]] : '0;
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_err   = err_p1;
  assign rsp_rdata = rdata_p1;
  assign req_ready = run_q;
  assign init_done = run_q;

endmodule

// File: tb/tb_data_memory_param.sv
module tb_data_memory_param;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int D  = 20;
`ifdef DMEM_CLEAR_EN
  localparam int READY_AT = D;
`else
  localparam int READY_AT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  data_memory_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: word contents with a "known" flag, cycles since
  // reset release, and the expected response state.
  logic [DW-1:0] mm [32];
  bit            mk [32];
  int            edges;
  bit            e_vld, e_err, e_known;
  logic [DW-1:0] e_rd;

  typedef struct {
    bit            v;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            x_vld;
    bit            x_err;
    logic [DW-1:0] x_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk_vec(bit v, bit we, int a, int d, bit xv, bit xe, int xr);
    vec_t t;
    t.v = v; t.we = we; t.a = AW'(a); t.d = DW'(d);
    t.x_vld = xv; t.x_err = xe; t.x_rd = DW'(xr);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Called at posedge+1: asserts reset asynchronously, checks outputs clear
  // without a clock edge, holds two edges, releases at posedge+1.
  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err",   rsp_err,   0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);
    e_vld = 0; e_err = 0; e_rd = '0; e_known = 1; edges = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; model predicts the response from the rules and
  // all outputs are compared at posedge+1.
  task automatic cycle(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    acc = v && (edges >= READY_AT);
    @(posedge clk);
    if (acc) begin
      e_vld = 1;
      e_err = (int'(a) >= D);
      if (int'(a) >= D) begin
        e_rd = '0; e_known = 1;
      end else if (we) begin
        mm[a] = d; mk[a] = 1; e_rd = '0; e_known = 1;
      end else begin
        e_rd = mm[a]; e_known = mk[a];
      end
    end else begin
      e_vld = 0; e_err = 0;
    end
    edges++;
`ifdef DMEM_CLEAR_EN
    if (edges == D) begin
      for (int i = 0; i < D; i++) begin mm[i] = '0; mk[i] = 1; end
    end
`endif
    #1;
    cyc++;
    chk("rsp_valid", rsp_valid, e_vld);
    chk("rsp_err",   rsp_err,   e_err);
    if (e_known) chk("rsp_rdata", rsp_rdata, e_rd);
    chk("req_ready", req_ready, edges >= READY_AT);
    chk("init_done", init_done, edges >= READY_AT);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin mm[i] = '0; mk[i] = 0; end
    rst_n = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    e_vld = 0; e_err = 0; e_rd = '0; e_known = 1; edges = 0;
    #2;
    apply_reset();

    // Request held high through INIT: nothing accepted until ready; the last
    // cycle's read of word 7 is accepted.
    repeat (READY_AT + 1) cycle(1'b1, 1'b0, AW'(7), '0);
`ifdef DMEM_CLEAR_EN
    chk("clear_word7", rsp_rdata, 0);
`endif

    tbl.push_back(mk_vec(1, 1,  3, 'hA5, 1, 0, 'h00));
    tbl.push_back(mk_vec(1, 0,  3, 'h00, 1, 0, 'hA5));
    tbl.push_back(mk_vec(1, 1,  0, 'h11, 1, 0, 'h00));
    tbl.push_back(mk_vec(1, 1,  1, 'h22, 1, 0, 'h00));
    tbl.push_back(mk_vec(1, 1,  2, 'h33, 1, 0, 'h00));
    tbl.push_back(mk_vec(1, 1,  3, 'h44, 1, 0, 'h00));
    tbl.push_back(mk_vec(1, 0,  0, 'h00, 1, 0, 'h11));
    tbl.push_back(mk_vec(1, 0,  1, 'h00, 1, 0, 'h22));
    tbl.push_back(mk_vec(1, 0,  2, 'h00, 1, 0, 'h33));
    tbl.push_back(mk_vec(1, 0,  3, 'h00, 1, 0, 'h44));
    tbl.push_back(mk_vec(0, 0,  0, 'h00, 0, 0, 'h44));
    tbl.push_back(mk_vec(1, 1, 19, 'h3C, 1, 0, 'h00));
    tbl.push_back(mk_vec(1, 1, 25, 'hFF, 1, 1, 'h00));
    tbl.push_back(mk_vec(1, 0, 25, 'h00, 1, 1, 'h00));
    tbl.push_back(mk_vec(1, 1, 20, 'h77, 1, 1, 'h00));
    tbl.push_back(mk_vec(1, 0, 20, 'h00, 1, 1, 'h00));
    tbl.push_back(mk_vec(1, 1, 31, 'hEE, 1, 1, 'h00));
    tbl.push_back(mk_vec(1, 0, 19, 'h00, 1, 0, 'h3C));
    tbl.push_back(mk_vec(0, 1, 19, 'h55, 0, 0, 'h3C));

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_vld", i), rsp_valid, tbl[i].x_vld);
      chk($sformatf("tbl%0d_err", i), rsp_err,   tbl[i].x_err);
      chk($sformatf("tbl%0d_rd",  i), rsp_rdata, tbl[i].x_rd);
    end

    // Reset during RUN with non-zero held read data.
    apply_reset();

    // Reset again after 10 clear cycles; the clear must restart from zero.
    repeat (10) cycle(1'b1, 1'b1, AW'(4), 8'h99);
    apply_reset();
    repeat (READY_AT + 1) cycle(1'b1, 1'b0, AW'(4), '0);

    // Write then immediately read the same word.
    cycle(1'b1, 1'b1, AW'(0), 8'h5A);
    cycle(1'b1, 1'b0, AW'(0), '0);
    chk("wr_rd_addr0", rsp_rdata, 8'h5A);
    cycle(1'b1, 1'b1, AW'(19), 8'hC3);
    cycle(1'b1, 1'b0, AW'(19), '0);
    chk("wr_rd_addr19", rsp_rdata, 8'hC3);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, 31)), DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
